fp_int_serial_mul: RTL and testbench
====================================

FP_INT_SERIAL_MUL -- requirements
Module: fp_int_serial_mul

Interface
REQ-001 Parameter EXP_W, default 5, activation exponent width.
REQ-002 Parameter MAN_W, default 10, activation stored-mantissa width.
REQ-003 Parameter W_MAX, default 8, maximum weight precision in bits.
REQ-004 Derived ACC_W = MAN_W+1+W_MAX, the product mantissa width.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset; synchronous and active-low.
REQ-007 set  in  1  when high in IDLE, latch precision.
REQ-008 precision  in  4  weight bit count P.
REQ-009 in_valid / in_ready  in / out  1 / 1  operand handshake.
REQ-010 act  in  1+EXP_W+MAN_W  fp activation {sign, exp, mantissa}.
REQ-011 w_sign  in  1  weight sign, sampled with act (unsigned mode only).
REQ-012 w_bit / w_valid  in / in  1 / 1  serial weight bit, MSB first, and its qualifier.
REQ-013 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-014 sign_out  out  1  product sign.
REQ-015 exp_out  out  EXP_W  activation exponent, passed through unchanged.
REQ-016 mant_out  out  ACC_W  product magnitude, unsigned fixed-point.

Function
REQ-017 FSM states: IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-018 Latched precision: 0 or >W_MAX loads W_MAX; 1..W_MAX loads as given.
REQ-019 set outside IDLE is ignored; set together with in_valid in IDLE latches precision and the accepted operand uses the new value.
REQ-020 IDLE with in_valid: capture act, w_sign, exponent; clear acc and bit counter; go to SHIFT.
REQ-021 Hidden bit = 1 when exp != 0; hidden bit = 0 when exp == 0 (subnormal); M = {hidden, mantissa}.
REQ-022 SHIFT, per cycle with w_valid=1: acc <= (acc<<1) + (w_bit ? M : 0); counter increments.
REQ-023 w_valid=0 in SHIFT: acc and counter hold (stall); no timeout.
REQ-024 After the P-th accepted bit, go to DONE.
REQ-025 Latency with w_valid continuously high: accept at cycle T; bits at T+1..T+P; out_valid at T+P+1.
REQ-026 DONE: outputs stable until out_ready; on out_valid&out_ready go to IDLE, in_ready high the next cycle (no same-cycle re-accept).
REQ-027 sign_out = act_sign ^ weight_sign, forced to 0 when mant_out == 0.
REQ-028 No rounding or truncation; ACC_W holds the full product for all P <= W_MAX.

Reset
REQ-029 rst=0 at a clock edge: state IDLE; acc, counter, sign_out, exp_out, mant_out = 0; latched precision = 4.
REQ-030 Reset mid-SHIFT or mid-DONE aborts the operation with no output produced; reset overrides set and in_valid.

Configuration
REQ-031 Macro FP_INT_SIGNED_W_EN, when defined: weight is P-bit two's complement; first bit has weight -2^(P-1).
REQ-032 With FP_INT_SIGNED_W_EN: acc is signed with one extra bit; w_sign is ignored; weight_sign = sign of acc; mant_out = |acc|.
REQ-033 Without FP_INT_SIGNED_W_EN: weight is an unsigned magnitude; weight_sign = w_sign; no extra acc bit.

Verification
REQ-034 Unsigned, P=4, act=0x3C00, w_sign=0, bits 0101 -> out_valid at T+5, mant_out=0x1400, exp_out=15, sign_out=0.
REQ-035 FP_INT_SIGNED_W_EN, P=4, act=0x3C00, bits 1011 (-5) -> mant_out=0x1400, sign_out=1; with act=0xBC00 -> sign_out=0.
REQ-036 Subnormal: P=2, act=0x0001, bits 11 -> mant_out=3, exp_out=0; bits 00 with act=0x8001 -> mant_out=0, sign_out=0.
REQ-037 Stall/backpressure: P=4, w_valid low two cycles mid-stream -> out_valid at T+7 with unchanged result; out_ready low 3 cycles -> outputs held, in_ready=0.
REQ-038 Control: set with precision=9 in IDLE -> P=8 (W_MAX); set during SHIFT ignored; rst=0 mid-SHIFT -> IDLE with all outputs 0 and no out_valid.

Source files
------------

// File: rtl/fp_int_serial_mul.sv
// Bit-serial multiply of a floating-point activation by an integer weight fed MSB first.
// Define FP_INT_SIGNED_W_EN to treat the weight as P-bit two's complement instead of sign+magnitude.
module fp_int_serial_mul #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int W_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set,
    input  logic [3:0]               precision,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     act,
    input  logic                     w_sign,
    input  logic                     w_bit,
    input  logic                     w_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sign_out,
    output logic [EXP_W-1:0]         exp_out,
    output logic [MAN_W+W_MAX:0]     mant_out
);
    localparam int ACC_W = MAN_W + 1 + W_MAX;
`ifdef FP_INT_SIGNED_W_EN
    localparam int AW = ACC_W + 1;
`else
    localparam int AW = ACC_W;
`endif
    localparam logic [4:0] WMAX5 = 5'(W_MAX);
    localparam logic [3:0] WMAX4 = 4'(W_MAX);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q;
    logic [3:0]        prec_q, prec_d, cnt_q;
    logic [MAN_W:0]    m_q;
    logic              act_sign_q, sign_q, sign_d, w_neg;
    logic [EXP_W-1:0]  exp_q;
    logic [ACC_W-1:0]  mant_q, mag_d;
    logic [AW-1:0]     acc_q, acc_d, addend;

    always_comb begin
        prec_d = prec_q;
        if (set) begin
            prec_d = (precision == 4'd0 || {1'b0, precision} > WMAX5) ? WMAX4 : precision;
        end
    end

`ifdef FP_INT_SIGNED_W_EN
    logic [AW-1:0] mag_full;
    logic          unused_w_sign, unused_mag_top;
    assign unused_w_sign  = w_sign;
    assign unused_mag_top = mag_full[AW-1];

    // The first (MSB) weight bit carries weight -2^(P-1), so it subtracts M.
    always_comb begin
        addend = w_bit ? AW'(m_q) : '0;
        if (w_bit && cnt_q == 4'd0) addend = -AW'(m_q);
        acc_d    = (acc_q << 1) + addend;
        w_neg    = acc_d[AW-1];
        mag_full = w_neg ? -acc_d : acc_d;
        mag_d    = mag_full[ACC_W-1:0];
        sign_d   = (act_sign_q ^ w_neg) & (|mag_d);
    end
`else
    logic w_sign_q;

    always_comb begin
        addend = w_bit ? AW'(m_q) : '0;
        acc_d  = (acc_q << 1) + addend;
        w_neg  = w_sign_q;
        mag_d  = acc_d;
        sign_d = (act_sign_q ^ w_neg) & (|mag_d);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            prec_q     <= 4'd4;
            cnt_q      <= '0;
            acc_q      <= '0;
            m_q        <= '0;
            act_sign_q <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            sign_q     <= 1'b0;
`ifndef FP_INT_SIGNED_W_EN
            w_sign_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    prec_q <= prec_d;
                    if (in_valid) begin
                        m_q        <= {|act[MAN_W +: EXP_W], act[MAN_W-1:0]};
                        act_sign_q <= act[EXP_W+MAN_W];
                        exp_q      <= act[MAN_W +: EXP_W];
`ifndef FP_INT_SIGNED_W_EN
                        w_sign_q   <= w_sign;
`endif
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == prec_q - 4'd1) begin
                            mant_q  <= mag_d;
                            sign_q  <= sign_d;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sign_out  = sign_q;
    assign exp_out   = exp_q;
    assign mant_out  = mant_q;
endmodule

// File: tb/tb_fp_int_serial_mul.sv
// Self-checking bench for fp_int_serial_mul: vector table plus stall, backpressure and reset sequences.
module tb_fp_int_serial_mul;
    logic        clk = 1'b0;
    logic        rst, set, in_valid, in_ready, w_sign, w_bit, w_valid;
    logic        out_valid, out_ready, sign_out;
    logic [3:0]  precision;
    logic [15:0] act;
    logic [4:0]  exp_out;
    logic [18:0] mant_out;

    always #5 clk = ~clk;

    fp_int_serial_mul dut (
        .clk(clk), .rst(rst), .set(set), .precision(precision),
        .in_valid(in_valid), .in_ready(in_ready), .act(act), .w_sign(w_sign),
        .w_bit(w_bit), .w_valid(w_valid), .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out)
    );

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [18:0] m;
    } res_t;

    typedef struct {
        logic [3:0]  pr;
        logic [15:0] a;
        logic        ws;
        logic [7:0]  bits;
        int          np;
        logic        s;
        logic [4:0]  e;
        logic [18:0] m;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    res_t sb[$];
    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        res_t r;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                r = sb.pop_front();
                chk("sign_out", {31'd0, sign_out}, {31'd0, r.s});
                chk("exp_out", {27'd0, exp_out}, {27'd0, r.e});
                chk("mant_out", {13'd0, mant_out}, {13'd0, r.m});
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input vec_t v, input logic do_set, input int stall_at,
                          input int stall_len, input int rdy_hold, input logic set_mid);
        wait_ready();
        set = do_set; precision = v.pr; act = v.a; w_sign = v.ws; in_valid = 1'b1;
        out_ready = (rdy_hold == 0);
        sb.push_back('{v.s, v.e, v.m});
        @(posedge clk); #1;
        in_valid = 1'b0; set = 1'b0;
        act = 16'($urandom); w_sign = 1'($urandom);
        chk("accept_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < v.np; i++) begin
            if (i == stall_at) begin
                w_valid = 1'b0; w_bit = 1'b1;
                repeat (stall_len) begin @(posedge clk); #1; end
            end
            chk("early_valid", {31'd0, out_valid}, 32'd0);
            w_valid = 1'b1; w_bit = v.bits[v.np-1-i];
            if (set_mid && i == 1) begin set = 1'b1; precision = 4'd2; end
            @(posedge clk); #1;
            set = 1'b0;
        end
        w_valid = 1'b0;
        chk("done_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < rdy_hold; k++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_mant", {13'd0, mant_out}, {13'd0, v.m});
            chk("hold_sign", {31'd0, sign_out}, {31'd0, v.s});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //        pr     act       ws    bits   np  s     e      m
`ifdef FP_INT_SIGNED_W_EN
        vt[0] = '{4'd4, 16'h3C00, 1'b0, 8'h05, 4, 1'b0, 5'd15, 19'h01400};
        vt[1] = '{4'd4, 16'h3C00, 1'b0, 8'h0B, 4, 1'b1, 5'd15, 19'h01400};
        vt[2] = '{4'd4, 16'hBC00, 1'b0, 8'h0B, 4, 1'b0, 5'd15, 19'h01400};
        vt[3] = '{4'd2, 16'h0001, 1'b0, 8'h03, 2, 1'b1, 5'd0,  19'h00001};
        vt[4] = '{4'd2, 16'h8001, 1'b1, 8'h00, 2, 1'b0, 5'd0,  19'h00000};
        vt[5] = '{4'd9, 16'h7BFF, 1'b1, 8'hFF, 8, 1'b1, 5'd30, 19'h007FF};
        vt[6] = '{4'd3, 16'hC123, 1'b0, 8'h06, 3, 1'b0, 5'd16, 19'h00A46};
        vt[7] = '{4'd1, 16'h4000, 1'b1, 8'h01, 1, 1'b1, 5'd16, 19'h00400};
        vt[8] = '{4'd0, 16'h3C00, 1'b0, 8'h80, 8, 1'b1, 5'd15, 19'h20000};
        vt[9] = '{4'd5, 16'h0200, 1'b0, 8'h13, 5, 1'b1, 5'd0,  19'h01A00};
`else
        vt[0] = '{4'd4, 16'h3C00, 1'b0, 8'h05, 4, 1'b0, 5'd15, 19'h01400};
        vt[1] = '{4'd4, 16'h3C00, 1'b0, 8'h0B, 4, 1'b0, 5'd15, 19'h02C00};
        vt[2] = '{4'd4, 16'hBC00, 1'b0, 8'h0B, 4, 1'b1, 5'd15, 19'h02C00};
        vt[3] = '{4'd2, 16'h0001, 1'b0, 8'h03, 2, 1'b0, 5'd0,  19'h00003};
        vt[4] = '{4'd2, 16'h8001, 1'b1, 8'h00, 2, 1'b0, 5'd0,  19'h00000};
        vt[5] = '{4'd9, 16'h7BFF, 1'b1, 8'hFF, 8, 1'b1, 5'd30, 19'h7F701};
        vt[6] = '{4'd3, 16'hC123, 1'b0, 8'h06, 3, 1'b1, 5'd16, 19'h01ED2};
        vt[7] = '{4'd1, 16'h4000, 1'b1, 8'h01, 1, 1'b1, 5'd16, 19'h00400};
        vt[8] = '{4'd0, 16'h3C00, 1'b0, 8'h80, 8, 1'b0, 5'd15, 19'h20000};
        vt[9] = '{4'd5, 16'h0200, 1'b0, 8'h13, 5, 1'b0, 5'd0,  19'h02600};
`endif
        rst = 1'b0; set = 1'b0; precision = 4'd0; in_valid = 1'b0; act = 16'h0;
        w_sign = 1'b0; w_bit = 1'b0; w_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mant", {13'd0, mant_out}, 32'd0);
        chk("rst_exp", {27'd0, exp_out}, 32'd0);
        chk("rst_sign", {31'd0, sign_out}, 32'd0);
        rst = 1'b1;

        // Reset precision (4) applies without any set.
        run_op(vt[0], 1'b0, -1, 0, 0, 1'b0);

        for (int i = 0; i < 10; i++) run_op(vt[i], 1'b1, -1, 0, 0, 1'b0);

        // Reset in the middle of SHIFT; prior precision was 5.
        wait_ready();
        act = 16'h7BFF; w_sign = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; w_valid = 1'b1; w_bit = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_mant", {13'd0, mant_out}, 32'd0);
        chk("abort_exp", {27'd0, exp_out}, 32'd0);
        chk("abort_sign", {31'd0, sign_out}, 32'd0);
        begin
            logic seen = 1'b0;
            repeat (6) begin
                @(posedge clk); #1;
                seen = seen | out_valid;
            end
            chk("abort_no_valid", {31'd0, seen}, 32'd0);
        end
        w_valid = 1'b0;
        run_op(vt[0], 1'b0, -1, 0, 0, 1'b0);

        // Stall two cycles mid-stream, then hold out_ready low three cycles.
        run_op(vt[0], 1'b1, 2, 2, 3, 1'b0);

        // set while shifting is ignored for this and the next operation.
        begin
            vec_t v = '{4'd4, 16'h3C00, 1'b0, 8'h03, 4, 1'b0, 5'd15, 19'h00C00};
            run_op(v, 1'b1, -1, 0, 0, 1'b1);
            run_op(v, 1'b0, -1, 0, 0, 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
